// File: rtl/dlx_fetch_queue.sv
// DLX instruction-fetch front end: owns the PC, keeps a single request to
// instruction memory outstanding, and buffers returned words in an in-order queue.
module dlx_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [31:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               squash_q, squash_d;

  logic               ack_ok;
  logic               push;
  logic               pop;
  logic               not_empty;
  logic [31:0]        pc_plus4;
  entry_t             head;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the branches below can leave a signal unassigned and infer a latch.
    pc_d      = pc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    squash_d  = squash_q;

    pc_plus4  = pc_q + 32'd4;
    head      = mem_q[rd_ptr_q];
    not_empty = (count_q != '0);

    // Request is held off while reset is asserted and while a dead response is pending.
    imem_req  = rst && (count_q < FULL) && !squash_q;
    imem_addr = pc_q;
    if_valid  = not_empty && !redirect;
    if_instr  = not_empty ? head.instr : 32'd0;
    if_pc4    = not_empty ? head.pc4   : 32'd0;

    ack_ok    = imem_ack && (imem_req || squash_q);
    push      = ack_ok && !squash_q && !redirect;
    pop       = if_valid && !stall;

    if (redirect) begin
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      // Anything in flight that does not complete now must have its response dropped.
      squash_d = (imem_req || squash_q) && !imem_ack;
    end else begin
      if (ack_ok && squash_q) squash_d = 1'b0;
      if (push) begin
        pc_d     = pc_plus4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      squash_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      squash_q <= squash_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; count gates every read, so
  // stale entries are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc4: pc_plus4, instr: imem_data};
  end

endmodule

// File: tb/tb_dlx_fetch_queue.sv
// Directed self-checking bench for dlx_fetch_queue (DEPTH=4, RESET_PC=0).
module tb_dlx_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;

  int n_checks = 0;
  int n_fail   = 0;

  dlx_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc4     (if_pc4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply this cycle's memory/redirect inputs and let outputs settle.
  task automatic drive(input logic a, input logic [31:0] d, input logic r, input logic [31:0] rp);
    imem_ack    = a;
    imem_data   = d;
    redirect    = r;
    redirect_pc = rp;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] instr, input logic [31:0] pc4);
    check({tag, " req"},   32'(imem_req),  32'(req));
    check({tag, " addr"},  imem_addr,      addr);
    check({tag, " valid"}, 32'(if_valid),  32'(vld));
    check({tag, " instr"}, if_instr,       instr);
    check({tag, " pc4"},   if_pc4,         pc4);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int n_acc;
    rst = 1'b0; stall = 1'b0;
    imem_ack = 1'b0; imem_data = '0; redirect = 1'b0; redirect_pc = '0;
    tick();
    tick();
    expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    expect_out("first", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Streaming: ack every cycle, data equals address.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'(4 * k), 1'b0, 32'd0);
      expect_out("stream", 1'b1, 32'(4 * k), k > 0,
                 (k > 0) ? 32'(4 * (k - 1)) : 32'd0, (k > 0) ? 32'(4 * k) : 32'd0);
      tick();
    end

    // Zero-wait memory while stalled: fills exactly DEPTH entries.
    do_reset();
    stall = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'd0, 1'b0, 32'd0);
      imem_ack  = imem_req;
      imem_data = imem_addr;
      if (imem_req) n_acc++;
      tick();
    end
    check("fill acks", 32'(n_acc), 32'd4);
    stall = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, 32'd0, 1'b0, 32'd0);
      expect_out("drain", j > 0, 32'h10, 1'b1, 32'(4 * j), 32'(4 * j + 4));
      tick();
    end
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    expect_out("drained", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0);

    // Redirect while the 0x8 fetch is outstanding; its late ack is dropped.
    do_reset();
    drive(1'b1, 32'h0, 1'b0, 32'd0);  expect_out("sq c0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b1, 32'h4, 1'b0, 32'd0);  expect_out("sq c1", 1'b1, 32'h4, 1'b1, 32'h0, 32'h4); tick();
    drive(1'b0, 32'h0, 1'b0, 32'd0);  expect_out("sq c2", 1'b1, 32'h8, 1'b1, 32'h4, 32'h8); tick();
    drive(1'b0, 32'h0, 1'b1, 32'h100); expect_out("sq c3", 1'b1, 32'h8, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b0, 32'h0, 1'b0, 32'd0);  expect_out("sq c4", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b1, 32'hDEAD, 1'b0, 32'd0); expect_out("sq c5", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b1, 32'hA0A0_0100, 1'b0, 32'd0); expect_out("sq c6", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b0, 32'h0, 1'b0, 32'd0);  expect_out("sq c7", 1'b1, 32'h104, 1'b1, 32'hA0A0_0100, 32'h104); tick();

    // Redirect coinciding with the ack for 0xC, queue holding three entries.
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0, 32'd0);
      tick();
    end
    drive(1'b1, 32'hC, 1'b1, 32'h200);
    check("rd-ack addr", imem_addr, 32'hC);
    check("rd-ack valid", 32'(if_valid), 32'd0);
    tick();
    stall = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'd0); expect_out("rd-ack n1", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b0, 32'h0, 1'b0, 32'd0); expect_out("rd-ack n2", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);

    // Second redirect while the first squash is still pending.
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 32'h200); expect_out("rr c0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b0, 32'h0, 1'b1, 32'h300); expect_out("rr c1", 1'b0, 32'h200, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b1, 32'hBAD0, 1'b0, 32'd0); expect_out("rr c2", 1'b0, 32'h300, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b1, 32'h3003, 1'b0, 32'd0); expect_out("rr c3", 1'b1, 32'h300, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b0, 32'h0, 1'b0, 32'd0);  expect_out("rr c4", 1'b1, 32'h304, 1'b1, 32'h3003, 32'h304); tick();

    // Full queue, then simultaneous push/pop, then reset mid-stream.
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(32'h100 + 4 * i), 1'b0, 32'd0);
      expect_out("full fill", 1'b1, 32'(4 * i), i > 0, (i > 0) ? 32'h100 : 32'h0, (i > 0) ? 32'h4 : 32'h0);
      tick();
    end
    stall = 1'b0;
    drive(1'b1, 32'hBAD, 1'b0, 32'd0);  expect_out("pp c4", 1'b0, 32'h10, 1'b1, 32'h100, 32'h4);  tick();
    drive(1'b1, 32'h110, 1'b0, 32'd0);  expect_out("pp c5", 1'b1, 32'h10, 1'b1, 32'h104, 32'h8);  tick();
    drive(1'b1, 32'h114, 1'b0, 32'd0);  expect_out("pp c6", 1'b1, 32'h14, 1'b1, 32'h108, 32'hC);  tick();
    drive(1'b1, 32'h118, 1'b0, 32'd0);  expect_out("pp c7", 1'b1, 32'h18, 1'b1, 32'h10C, 32'h10); tick();
    drive(1'b0, 32'h0, 1'b0, 32'd0);    expect_out("pp c8", 1'b1, 32'h1C, 1'b1, 32'h110, 32'h14);
    rst = 1'b0;
    drive(1'b1, 32'h999, 1'b1, 32'h500);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'd0);    expect_out("mid rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    drive(1'b1, 32'h55, 1'b0, 32'd0);   expect_out("rst rel", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);  tick();
    drive(1'b0, 32'h0, 1'b0, 32'd0);    expect_out("rst out", 1'b1, 32'h4, 1'b1, 32'h55, 32'h4);  tick();

    // pc+4 wraps at the top of the address space.
    do_reset();
    drive(1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC); tick();
    drive(1'b1, 32'h77, 1'b0, 32'd0); expect_out("wrap c1", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b0, 32'h0, 1'b0, 32'd0);  expect_out("wrap c2", 1'b1, 32'h0, 1'b1, 32'h77, 32'h0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
